flash_read_ctrl: RTL and testbench
==================================

Name: flash_read_ctrl

Overview:
- SPI flash read engine for the iCESugar configuration flash.
- Sits directly downstream of the sub-clock divider and consumes its slow SPI clock (sck_in) and its one-cycle MOSI-update strobe (shift_strobe).
- Issues a READ command plus a 24-bit address, then streams N data bytes to the fabric as one-cycle valid pulses.
- Drives flash CS#, SCK and MOSI, and samples MISO.

Parameters:
CMD_READ, 8'h03, read opcode sent MSB first
LEN_WIDTH, 16, width of the byte-count input
CS_SETUP_CYCLES, 4, top_clk cycles of CS# low before the first strobe is honoured
CS_HOLD_CYCLES, 4, top_clk cycles of CS# low after the last SCK falling edge

Ports:
top_clk  input  1  system clock; all state on its rising edge
top_rst_n  input  1  asynchronous active-low reset
sck_in  input  1  free-running divided clock from the sub-clock divider (8 top_clk period: 5 low, 3 high)
shift_strobe  input  1  one-cycle pulse inside each sck_in low phase; MOSI/enable update point
start  input  1  one-cycle request; sampled only in IDLE
addr  input  24  flash byte address, latched on accepted start
byte_len  input  LEN_WIDTH  number of bytes to read, latched on accepted start
busy  output  1  high from accepted start until done
data_out  output  8  last received byte, MSB first on the wire
data_valid  output  1  one-cycle pulse when data_out is updated
done  output  1  one-cycle pulse at end of transaction
flash_cs_n  output  1  chip select, active low
flash_sck  output  1  gated SPI clock
flash_mosi  output  1  serial data to flash
flash_miso  input  1  serial data from flash

Behaviour:
- Reset (async, immediate): flash_cs_n=1, flash_sck=0, flash_mosi=0, busy=0, data_valid=0, done=0, data_out=8'h00, FSM=IDLE. Reset mid-transfer aborts instantly. No partial byte or done is emitted.
- Gating: flash_sck <= sck_en & sck_in (registered, one top_clk lag). sck_en changes only on shift_strobe, so no runt SCK pulses occur. A "bit edge" is a detected 0->1 transition of the registered flash_sck.
- IDLE: start=1 and byte_len!=0 -> latch addr/len, busy=1, cs_n=0, go CS_SETUP. start with byte_len==0 -> done pulse next cycle; CS# stays high; busy stays 0. start while busy is ignored.
- CS_SETUP: count CS_SETUP_CYCLES. On the first shift_strobe after expiry -> go CMD, drive MOSI = shift-register MSB, sck_en=1.
- CMD/ADDR: 32-bit shift register {CMD_READ, addr}. On each shift_strobe after a completed bit edge, shift left and drive the new MSB. After the 32nd bit edge -> go DATA.
- DATA: on each bit edge, sample flash_miso into an 8-bit shift register (LSB-in). After 8 bit edges, data_out <= byte and data_valid=1 for one cycle (same cycle as the update), then decrement remaining. MOSI is held 0 in DATA.
- When remaining reaches 0: at the next shift_strobe, sck_en=0 -> go CS_HOLD.
- CS_HOLD: count CS_HOLD_CYCLES, then cs_n=1, done=1 for one cycle, busy=0 -> IDLE. A start in the same cycle as done is ignored; start is honoured from the next cycle.
- Bit counter 6 bits; remaining counter LEN_WIDTH bits. Max len 2^LEN_WIDTH-1. Address is not incremented internally; the flash auto-increments, and reads wrap at 16 MiB as the device does.
- Throughput: one byte per 64 top_clk. First data_valid occurs at most CS_SETUP_CYCLES + 8 + 40*8 + 8 top_clk after start.

Optional Feature:
FLASH_FAST_READ_EN
- Defined: opcode is 8'h0B, followed by 8 dummy SCK cycles (MOSI=0, MISO ignored) after the address before DATA. This adds exactly 64 top_clk of latency to the first byte.
- Undefined: CMD_READ is used with no dummy cycles, as above.

Test Plan:
- Reset, then idle 100 cycles -> cs_n=1, sck=0, busy=0, no valid/done.
- start, addr=24'h100000, len=1, flash model returns 8'hA5 -> MOSI sequence 03 10 00 00; exactly 32+8 SCK rises; data_out=8'hA5 with one data_valid; done once; cs_n low throughout.
- len=4, model returns 11,22,33,44 -> four data_valid pulses 64 top_clk apart in that order; cs_n never toggles mid-burst.
- start with len=0 -> done one cycle later; cs_n never low; no SCK.
- top_rst_n low during ADDR bit 12 -> cs_n=1 and sck=0 the same instant. A subsequent start with addr=24'h000010, len=2 completes normally.
- FLASH_FAST_READ_EN defined, len=1 -> opcode 0B, 8 dummy SCK cycles, 48 SCK rises total, correct byte returned.

Source files
------------

// File: rtl/flash_read_ctrl.sv
// -----------------------------------------------------------------------------
// flash_read_ctrl
//
// SPI flash read engine. Sends a read opcode plus 24-bit address MSB first,
// then streams byte_len bytes back to the fabric as one-cycle data_valid
// pulses. The slow SPI clock and its MOSI-update strobe come from an upstream
// sub-clock divider; this block only gates that clock onto the flash pin.
//
// Optional feature macro: FLASH_FAST_READ_EN
//   defined   -> opcode 8'h0B followed by 8 dummy SCK cycles before data
//   undefined -> opcode CMD_READ, data follows the address directly
//
// Ports:
//   top_clk, top_rst_n   system clock / asynchronous active-low reset
//   sck_in               free-running divided SPI clock
//   shift_strobe         one-cycle pulse inside each sck_in low phase
//   start                one-cycle request, honoured only when idle
//   addr, byte_len       transfer address and byte count, latched on start
//   busy                 high from accepted start until done
//   data_out, data_valid received byte and its one-cycle qualifier
//   done                 one-cycle end-of-transaction pulse
//   flash_cs_n, flash_sck, flash_mosi, flash_miso   flash pins
// -----------------------------------------------------------------------------
module flash_read_ctrl #(
    parameter logic [7:0] CMD_READ        = 8'h03,
    parameter int         LEN_WIDTH       = 16,
    parameter int         CS_SETUP_CYCLES = 4,
    parameter int         CS_HOLD_CYCLES  = 4
) (
    input  logic                 top_clk,
    input  logic                 top_rst_n,
    input  logic                 sck_in,
    input  logic                 shift_strobe,
    input  logic                 start,
    input  logic [23:0]          addr,
    input  logic [LEN_WIDTH-1:0] byte_len,
    output logic                 busy,
    output logic [7:0]           data_out,
    output logic                 data_valid,
    output logic                 done,
    output logic                 flash_cs_n,
    output logic                 flash_sck,
    output logic                 flash_mosi,
    input  logic                 flash_miso
);

`ifdef FLASH_FAST_READ_EN
    localparam logic [7:0] OPCODE = 8'h0B;
`else
    localparam logic [7:0] OPCODE = CMD_READ;
`endif

    localparam logic [7:0] SETUP_LAST = 8'(CS_SETUP_CYCLES);
    localparam logic [7:0] HOLD_LAST  = 8'(CS_HOLD_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CS_SETUP,
        S_CMD,
        S_DUMMY,
        S_DATA,
        S_CS_HOLD
    } state_t;

    state_t                r_state, w_state_next;
    logic [7:0]            r_wait, w_wait_next;
    logic [5:0]            r_bit_cnt, w_bit_cnt_next;
    logic [LEN_WIDTH-1:0]  r_remaining, w_remaining_next;
    logic [31:0]           r_sreg, w_sreg_next;
    logic [6:0]            r_rx, w_rx_next;          // first 7 bits of the byte in flight
    logic                  r_edge_seen, w_edge_seen_next;
    logic                  r_sck_en, w_sck_en_next;
    logic                  r_cs_n, w_cs_n_next;
    logic                  r_mosi, w_mosi_next;
    logic                  r_busy, w_busy_next;
    logic [7:0]            r_data_out, w_data_out_next;
    logic                  r_data_valid, w_data_valid_next;
    logic                  r_done, w_done_next;
    logic                  r_sck, r_sck_q;
    logic                  w_bit_edge;

    // Rising edge of the clock actually presented to the flash.
    assign w_bit_edge = r_sck & ~r_sck_q;

    always_ff @(posedge top_clk or negedge top_rst_n) begin
        if (!top_rst_n) begin
            r_state      <= S_IDLE;
            r_wait       <= '0;
            r_bit_cnt    <= '0;
            r_remaining  <= '0;
            r_sreg       <= '0;
            r_rx         <= '0;
            r_edge_seen  <= 1'b0;
            r_sck_en     <= 1'b0;
            r_cs_n       <= 1'b1;
            r_mosi       <= 1'b0;
            r_busy       <= 1'b0;
            r_data_out   <= 8'h00;
            r_data_valid <= 1'b0;
            r_done       <= 1'b0;
            r_sck        <= 1'b0;
            r_sck_q      <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_wait       <= w_wait_next;
            r_bit_cnt    <= w_bit_cnt_next;
            r_remaining  <= w_remaining_next;
            r_sreg       <= w_sreg_next;
            r_rx         <= w_rx_next;
            r_edge_seen  <= w_edge_seen_next;
            r_sck_en     <= w_sck_en_next;
            r_cs_n       <= w_cs_n_next;
            r_mosi       <= w_mosi_next;
            r_busy       <= w_busy_next;
            r_data_out   <= w_data_out_next;
            r_data_valid <= w_data_valid_next;
            r_done       <= w_done_next;
            // sck_en only moves on shift_strobe (sck_in low), so the gated
            // clock never produces a shortened high pulse.
            r_sck        <= r_sck_en & sck_in;
            r_sck_q      <= r_sck;
        end
    end

    always_comb begin
        w_state_next      = r_state;
        w_wait_next       = r_wait;
        w_bit_cnt_next    = r_bit_cnt;
        w_remaining_next  = r_remaining;
        w_sreg_next       = r_sreg;
        w_rx_next         = r_rx;
        w_edge_seen_next  = r_edge_seen;
        w_sck_en_next     = r_sck_en;
        w_cs_n_next       = r_cs_n;
        w_mosi_next       = r_mosi;
        w_busy_next       = r_busy;
        w_data_out_next   = r_data_out;
        w_data_valid_next = 1'b0;
        w_done_next       = 1'b0;

        case (r_state)
            S_IDLE: begin
                // A start coinciding with the done pulse is dropped.
                if (start && !r_done) begin
                    if (byte_len != '0) begin
                        w_sreg_next      = {OPCODE, addr};
                        w_remaining_next = byte_len;
                        w_busy_next      = 1'b1;
                        w_cs_n_next      = 1'b0;
                        w_wait_next      = '0;
                        w_state_next     = S_CS_SETUP;
                    end else begin
                        w_done_next = 1'b1;
                    end
                end
            end

            S_CS_SETUP: begin
                if (r_wait != SETUP_LAST) begin
                    w_wait_next = r_wait + 8'd1;
                end else if (shift_strobe) begin
                    w_mosi_next      = r_sreg[31];
                    w_sck_en_next    = 1'b1;
                    w_bit_cnt_next   = '0;
                    w_edge_seen_next = 1'b0;
                    w_state_next     = S_CMD;
                end
            end

            S_CMD: begin
                if (w_bit_edge) begin
                    w_edge_seen_next = 1'b1;
                    if (r_bit_cnt == 6'd31) begin
                        w_bit_cnt_next = '0;
                        w_mosi_next    = 1'b0;
`ifdef FLASH_FAST_READ_EN
                        w_state_next   = S_DUMMY;
`else
                        w_state_next   = S_DATA;
`endif
                    end else begin
                        w_bit_cnt_next = r_bit_cnt + 6'd1;
                    end
                end else if (shift_strobe && r_edge_seen) begin
                    // The flash has sampled the current bit; present the next.
                    w_sreg_next      = {r_sreg[30:0], 1'b0};
                    w_mosi_next      = r_sreg[30];
                    w_edge_seen_next = 1'b0;
                end
            end

            S_DUMMY: begin
                if (w_bit_edge) begin
                    if (r_bit_cnt == 6'd7) begin
                        w_bit_cnt_next = '0;
                        w_state_next   = S_DATA;
                    end else begin
                        w_bit_cnt_next = r_bit_cnt + 6'd1;
                    end
                end
            end

            S_DATA: begin
                if (w_bit_edge) begin
                    w_rx_next = {r_rx[5:0], flash_miso};
                    if (r_bit_cnt == 6'd7) begin
                        w_bit_cnt_next    = '0;
                        w_data_out_next   = {r_rx, flash_miso};
                        w_data_valid_next = 1'b1;
                        w_remaining_next  = r_remaining - LEN_WIDTH'(1);
                    end else begin
                        w_bit_cnt_next = r_bit_cnt + 6'd1;
                    end
                end else if (shift_strobe && (r_remaining == '0)) begin
                    // Stop the clock in its low phase after the final byte.
                    w_sck_en_next = 1'b0;
                    w_wait_next   = '0;
                    w_state_next  = S_CS_HOLD;
                end
            end

            S_CS_HOLD: begin
                if (r_wait == HOLD_LAST) begin
                    w_cs_n_next  = 1'b1;
                    w_done_next  = 1'b1;
                    w_busy_next  = 1'b0;
                    w_state_next = S_IDLE;
                end else begin
                    w_wait_next = r_wait + 8'd1;
                end
            end

            default: w_state_next = S_IDLE;
        endcase
    end

    assign busy       = r_busy;
    assign data_out   = r_data_out;
    assign data_valid = r_data_valid;
    assign done       = r_done;
    assign flash_cs_n = r_cs_n;
    assign flash_sck  = r_sck;
    assign flash_mosi = r_mosi;

endmodule

// File: tb/tb_flash_read_ctrl.sv
// -----------------------------------------------------------------------------
// tb_flash_read_ctrl
//
// Directed bench for flash_read_ctrl: models the sub-clock divider and a
// mode-0 SPI flash, and checks reset state, single and burst reads, the
// zero-length request, start filtering, and reset in the middle of a transfer.
// -----------------------------------------------------------------------------
module tb_flash_read_ctrl;

`ifdef FLASH_FAST_READ_EN
    localparam int         HDR   = 40;
    localparam logic [7:0] OPC   = 8'h0B;
    localparam int         EXTRA = 64;
`else
    localparam int         HDR   = 32;
    localparam logic [7:0] OPC   = 8'h03;
    localparam int         EXTRA = 0;
`endif
    localparam int LAT_MAX = 4 + 8 + 40 * 8 + 8 + EXTRA;

    logic        top_clk      = 1'b0;
    logic        top_rst_n    = 1'b0;
    logic        sck_in       = 1'b0;
    logic        shift_strobe = 1'b0;
    logic        start        = 1'b0;
    logic [23:0] addr         = 24'h0;
    logic [15:0] byte_len     = 16'h0;
    logic        flash_miso   = 1'b0;
    logic        busy;
    logic [7:0]  data_out;
    logic        data_valid;
    logic        done;
    logic        flash_cs_n;
    logic        flash_sck;
    logic        flash_mosi;

    flash_read_ctrl dut (
        .top_clk      (top_clk),
        .top_rst_n    (top_rst_n),
        .sck_in       (sck_in),
        .shift_strobe (shift_strobe),
        .start        (start),
        .addr         (addr),
        .byte_len     (byte_len),
        .busy         (busy),
        .data_out     (data_out),
        .data_valid   (data_valid),
        .done         (done),
        .flash_cs_n   (flash_cs_n),
        .flash_sck    (flash_sck),
        .flash_mosi   (flash_mosi),
        .flash_miso   (flash_miso)
    );

    initial forever #5 top_clk = ~top_clk;

    // Divider model: period 8, low for 5 cycles, high for 3, strobe in low phase.
    initial begin
        int div;
        div = 0;
        forever begin
            @(posedge top_clk);
            #1;
            div          = (div + 1) % 8;
            sck_in       = (div >= 5);
            shift_strobe = (div == 1);
        end
    end

    // Flash model and event monitor, sampled on the falling top_clk edge.
    int          cyc = 0;
    int          rise_cnt = 0;
    int          total_rises = 0, total_valid = 0, total_done = 0;
    int          total_cs_fall = 0, total_cs_rise = 0;
    logic [63:0] mosi_word = 64'h0;
    logic [7:0]  valid_data [64];
    int          valid_cyc  [64];
    logic [7:0]  model_bytes [8];

    initial begin
        logic       prev_sck, prev_cs;
        logic [7:0] b;
        int         idx;
        prev_sck = 1'b0;
        prev_cs  = 1'b1;
        forever begin
            @(negedge top_clk);
            cyc++;
            if (prev_cs && !flash_cs_n) begin
                total_cs_fall++;
                rise_cnt  = 0;
                mosi_word = 64'h0;
            end
            if (!prev_cs && flash_cs_n) total_cs_rise++;
            if (!prev_sck && flash_sck) begin
                total_rises++;
                if (rise_cnt < HDR) mosi_word = {mosi_word[62:0], flash_mosi};
                rise_cnt++;
            end
            if (prev_sck && !flash_sck && !flash_cs_n && rise_cnt >= HDR) begin
                idx        = rise_cnt - HDR;
                b          = model_bytes[(idx / 8) % 8];
                flash_miso = b[7 - (idx % 8)];
            end
            if (data_valid) begin
                valid_data[total_valid % 64] = data_out;
                valid_cyc[total_valid % 64]  = cyc;
                total_valid++;
            end
            if (done) total_done++;
            prev_sck = flash_sck;
            prev_cs  = flash_cs_n;
        end
    end

    int n_cmp = 0;
    int n_err = 0;
    int start_cyc = 0;
    int base_rises, base_valid, base_done, base_fall, base_rise;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        base_rises = total_rises;
        base_valid = total_valid;
        base_done  = total_done;
        base_fall  = total_cs_fall;
        base_rise  = total_cs_rise;
    endtask

    task automatic do_start(input logic [23:0] a, input logic [15:0] n);
        @(negedge top_clk);
        addr      = a;
        byte_len  = n;
        start     = 1'b1;
        start_cyc = cyc;
        @(negedge top_clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int bound);
        int n;
        n = 0;
        while (done !== 1'b1 && n < bound) begin
            @(negedge top_clk);
            n++;
        end
        check({tag, "_timeout"}, 64'(done !== 1'b1), 64'd0);
    endtask

    function automatic logic [63:0] exp_hdr(input logic [23:0] a);
`ifdef FLASH_FAST_READ_EN
        return {24'h0, OPC, a, 8'h00};
`else
        return {32'h0, OPC, a};
`endif
    endfunction

    initial begin
        int n;
        // ---------------- reset and idle ----------------
        repeat (3) @(negedge top_clk);
        check("rst_cs_n",     64'(flash_cs_n), 64'd1);
        check("rst_sck",      64'(flash_sck),  64'd0);
        check("rst_mosi",     64'(flash_mosi), 64'd0);
        check("rst_busy",     64'(busy),       64'd0);
        check("rst_data_out", 64'(data_out),   64'h00);
        top_rst_n = 1'b1;
        repeat (100) @(negedge top_clk);
        check("idle_cs_n",  64'(flash_cs_n),  64'd1);
        check("idle_sck",   64'(total_rises), 64'd0);
        check("idle_busy",  64'(busy),        64'd0);
        check("idle_valid", 64'(total_valid), 64'd0);
        check("idle_done",  64'(total_done),  64'd0);

        // ---------------- single byte read ----------------
        model_bytes[0] = 8'hA5;
        snap();
        do_start(24'h100000, 16'd1);
        check("A_busy",  64'(busy),       64'd1);
        check("A_cs_lo", 64'(flash_cs_n), 64'd0);
        wait_done("A", 1000);
        // request in the done cycle must be ignored
        addr = 24'h0; byte_len = 16'd1; start = 1'b1;
        @(negedge top_clk);
        start = 1'b0;
        repeat (3) @(negedge top_clk);
        check("A_hdr",     mosi_word, exp_hdr(24'h100000));
        check("A_rises",   64'(total_rises - base_rises), 64'(HDR + 8));
        check("A_nvalid",  64'(total_valid - base_valid), 64'd1);
        check("A_data",    64'(valid_data[base_valid % 64]), 64'hA5);
        check("A_lat",     64'((valid_cyc[base_valid % 64] - start_cyc) <= LAT_MAX), 64'd1);
        check("A_ndone",   64'(total_done - base_done), 64'd1);
        check("A_cs_fall", 64'(total_cs_fall - base_fall), 64'd1);
        check("A_cs_rise", 64'(total_cs_rise - base_rise), 64'd1);
        check("A_ign_busy", 64'(busy),       64'd0);
        check("A_ign_cs",   64'(flash_cs_n), 64'd1);

        // ---------------- four byte burst ----------------
        model_bytes[0] = 8'h11; model_bytes[1] = 8'h22;
        model_bytes[2] = 8'h33; model_bytes[3] = 8'h44;
        snap();
        do_start(24'h012345, 16'd4);
        repeat (50) @(negedge top_clk);
        addr = 24'hFFFFFF; byte_len = 16'd7; start = 1'b1;   // ignored while busy
        @(negedge top_clk);
        start = 1'b0;
        wait_done("B", 2000);
        repeat (3) @(negedge top_clk);
        check("B_hdr",    mosi_word, exp_hdr(24'h012345));
        check("B_nvalid", 64'(total_valid - base_valid), 64'd4);
        check("B_d0", 64'(valid_data[(base_valid + 0) % 64]), 64'h11);
        check("B_d1", 64'(valid_data[(base_valid + 1) % 64]), 64'h22);
        check("B_d2", 64'(valid_data[(base_valid + 2) % 64]), 64'h33);
        check("B_d3", 64'(valid_data[(base_valid + 3) % 64]), 64'h44);
        for (int i = 0; i < 3; i++)
            check("B_gap", 64'(valid_cyc[(base_valid + i + 1) % 64] - valid_cyc[(base_valid + i) % 64]), 64'd64);
        check("B_rises",   64'(total_rises - base_rises), 64'(HDR + 32));
        check("B_cs_fall", 64'(total_cs_fall - base_fall), 64'd1);
        check("B_cs_rise", 64'(total_cs_rise - base_rise), 64'd1);
        check("B_ndone",   64'(total_done - base_done), 64'd1);

        // ---------------- zero length ----------------
        snap();
        @(negedge top_clk);
        byte_len = 16'd0; start = 1'b1;
        @(negedge top_clk);
        start = 1'b0;
        check("C_done", 64'(done),       64'd1);
        check("C_busy", 64'(busy),       64'd0);
        check("C_cs",   64'(flash_cs_n), 64'd1);
        repeat (5) @(negedge top_clk);
        check("C_rises",   64'(total_rises - base_rises), 64'd0);
        check("C_cs_fall", 64'(total_cs_fall - base_fall), 64'd0);
        check("C_ndone",   64'(total_done - base_done), 64'd1);
        check("C_nvalid",  64'(total_valid - base_valid), 64'd0);

        // ---------------- reset during address phase ----------------
        model_bytes[0] = 8'h77; model_bytes[1] = 8'h88; model_bytes[2] = 8'h99;
        snap();
        do_start(24'hABCDEF, 16'd3);
        @(negedge top_clk);
        n = 0;
        while (rise_cnt < 20 && n < 500) begin
            @(negedge top_clk);
            n++;
        end
        check("D_reach_addr", 64'(rise_cnt >= 20), 64'd1);
        #1 top_rst_n = 1'b0;
        #1;
        check("D_rst_cs",   64'(flash_cs_n), 64'd1);
        check("D_rst_sck",  64'(flash_sck),  64'd0);
        check("D_rst_busy", 64'(busy),       64'd0);
        check("D_rst_mosi", 64'(flash_mosi), 64'd0);
        repeat (3) @(negedge top_clk);
        top_rst_n = 1'b1;
        repeat (20) @(negedge top_clk);
        check("D_no_valid", 64'(total_valid - base_valid), 64'd0);
        check("D_no_done",  64'(total_done - base_done),   64'd0);

        model_bytes[0] = 8'h5A; model_bytes[1] = 8'hC3;
        snap();
        do_start(24'h000010, 16'd2);
        wait_done("E", 2000);
        repeat (3) @(negedge top_clk);
        check("E_hdr",    mosi_word, exp_hdr(24'h000010));
        check("E_nvalid", 64'(total_valid - base_valid), 64'd2);
        check("E_d0",     64'(valid_data[(base_valid + 0) % 64]), 64'h5A);
        check("E_d1",     64'(valid_data[(base_valid + 1) % 64]), 64'hC3);
        check("E_rises",  64'(total_rises - base_rises), 64'(HDR + 16));
        check("E_ndone",  64'(total_done - base_done), 64'd1);
        check("E_cs",     64'(flash_cs_n), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
